// File: rtl/pn_swap_scheduler_pkg.sv
// Shared defaults and tag-bundle layout for the permutation-network swap scheduler.
// A tag bundle packs one flit's {src, age, vld}, with vld in the LSB.
package pn_swap_scheduler_pkg;

  localparam int TIME_W_DEF     = 8;
  localparam int ID_W_DEF       = 4;
  localparam int NUM_NODES_DEF  = 16;
  localparam int GOLD_EPOCH_DEF = 64;

  localparam int TAG_VLD_OFS = 0;
  localparam int TAG_AGE_OFS = 1;

  function automatic int tag_src_ofs(input int time_w);
    return 1 + time_w;
  endfunction

  function automatic int tag_w(input int time_w, input int id_w);
    return 1 + time_w + id_w;
  endfunction

endpackage

// File: rtl/pn_prio_cmp.sv
// Combinational 2x2 priority compare: swap=1 when y beats x.
// Order of precedence: valid, golden source, wrap-aware older age; ties keep x.
module pn_prio_cmp
  import pn_swap_scheduler_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic              x_vld,
  input  logic [TIME_W-1:0] x_age,
  input  logic [ID_W-1:0]   x_src,
  input  logic              y_vld,
  input  logic [TIME_W-1:0] y_age,
  input  logic [ID_W-1:0]   y_src,
  input  logic [ID_W-1:0]   gold_id,
  output logic              swap
);

  logic                     x_gold;
  logic                     y_gold;
  logic signed [TIME_W-1:0] age_diff;

  always_comb begin
    x_gold   = (x_src == gold_id);
    y_gold   = (y_src == gold_id);
    // y is older exactly when the modular difference y-x is negative
    age_diff = $signed(y_age - x_age);
    swap     = 1'b0;
    if (x_vld != y_vld) begin
      swap = y_vld;
    end else if (x_vld) begin
      if (x_gold != y_gold) swap = y_gold;
      else                  swap = (age_diff < 0);
    end
  end

endmodule

// File: rtl/pn_swap_scheduler.sv
// Two-stage swap scheduler for the 4-port permutation network with valid/ready
// backpressure and a rotating golden source that overrides age.
module pn_swap_scheduler
  import pn_swap_scheduler_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int NUM_NODES  = NUM_NODES_DEF,
  parameter int GOLD_EPOCH = GOLD_EPOCH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_vld,
  input  logic [4*TIME_W-1:0] in_age,
  input  logic [4*ID_W-1:0]   in_src,
  output logic [1:0]          sw_s0,
  output logic                sw_s0_valid,
  output logic [1:0]          sw_s1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_vld,
  output logic [ID_W-1:0]     gold_id
);

  localparam int TAG_W   = tag_w(TIME_W, ID_W);
  localparam int SRC_OFS = tag_src_ofs(TIME_W);
  localparam int CNT_W   = $clog2(GOLD_EPOCH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GOLD_EPOCH - 1);
  localparam logic [ID_W-1:0]  GOLD_LAST = ID_W'(NUM_NODES - 1);

  typedef logic [TAG_W-1:0] tag_t;

  function automatic tag_t pack_tag(input logic v, input logic [TIME_W-1:0] a,
                                    input logic [ID_W-1:0] s);
    tag_t t;
    t                      = '0;
    t[TAG_VLD_OFS]         = v;
    t[TAG_AGE_OFS+:TIME_W] = a;
    t[SRC_OFS+:ID_W]       = s;
    return t;
  endfunction

  function automatic logic f_vld(input tag_t t);
    return t[TAG_VLD_OFS];
  endfunction

  function automatic logic [TIME_W-1:0] f_age(input tag_t t);
    return t[TAG_AGE_OFS+:TIME_W];
  endfunction

  function automatic logic [ID_W-1:0] f_src(input tag_t t);
    return t[SRC_OFS+:ID_W];
  endfunction

  tag_t             tag_in [4];
  tag_t             tag_p0 [4];
  logic             vld_p0;
  logic             vld_p1;
  logic [1:0]       sw_p0;
  logic [1:0]       sw_p1;
  logic [3:0]       occ_p1;
  logic [CNT_W-1:0] epoch_cnt;
  logic             s0_adv;
  logic             s1_adv;
  logic             sw_a, sw_b, sw_c, sw_d;
  tag_t             a_up, a_lo, b_up, b_lo;
  logic [3:0]       occ_nxt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tag_in[i] = pack_tag(in_vld[i], in_age[i*TIME_W+:TIME_W], in_src[i*ID_W+:ID_W]);
    end
  end

  assign s1_adv   = !vld_p1 || out_ready;
  assign s0_adv   = !vld_p0 || s1_adv;
  assign in_ready = s0_adv;

  // ---- stage 0 compare: element A (din3,din2), element B (din1,din0)
  pn_prio_cmp #(.TIME_W(TIME_W), .ID_W(ID_W)) u_cmp_a (
    .x_vld(f_vld(tag_in[3])), .x_age(f_age(tag_in[3])), .x_src(f_src(tag_in[3])),
    .y_vld(f_vld(tag_in[2])), .y_age(f_age(tag_in[2])), .y_src(f_src(tag_in[2])),
    .gold_id(gold_id), .swap(sw_a)
  );

  pn_prio_cmp #(.TIME_W(TIME_W), .ID_W(ID_W)) u_cmp_b (
    .x_vld(f_vld(tag_in[1])), .x_age(f_age(tag_in[1])), .x_src(f_src(tag_in[1])),
    .y_vld(f_vld(tag_in[0])), .y_age(f_age(tag_in[0])), .y_src(f_src(tag_in[0])),
    .gold_id(gold_id), .swap(sw_b)
  );

  always_ff @(posedge clk) begin
    if (s0_adv) tag_p0 <= tag_in;
  end

  // ---- stage 1 compare on the stage-0 permuted tags: C (A.up,B.up), D (A.lo,B.lo)
  always_comb begin
    a_up = sw_p0[0] ? tag_p0[2] : tag_p0[3];
    a_lo = sw_p0[0] ? tag_p0[3] : tag_p0[2];
    b_up = sw_p0[1] ? tag_p0[0] : tag_p0[1];
    b_lo = sw_p0[1] ? tag_p0[1] : tag_p0[0];
  end

  pn_prio_cmp #(.TIME_W(TIME_W), .ID_W(ID_W)) u_cmp_c (
    .x_vld(f_vld(a_up)), .x_age(f_age(a_up)), .x_src(f_src(a_up)),
    .y_vld(f_vld(b_up)), .y_age(f_age(b_up)), .y_src(f_src(b_up)),
    .gold_id(gold_id), .swap(sw_c)
  );

  pn_prio_cmp #(.TIME_W(TIME_W), .ID_W(ID_W)) u_cmp_d (
    .x_vld(f_vld(a_lo)), .x_age(f_age(a_lo)), .x_src(f_src(a_lo)),
    .y_vld(f_vld(b_lo)), .y_age(f_age(b_lo)), .y_src(f_src(b_lo)),
    .gold_id(gold_id), .swap(sw_d)
  );

  always_comb begin
    occ_nxt[0] = sw_c ? f_vld(b_up) : f_vld(a_up);
    occ_nxt[1] = sw_c ? f_vld(a_up) : f_vld(b_up);
    occ_nxt[2] = sw_d ? f_vld(b_lo) : f_vld(a_lo);
    occ_nxt[3] = sw_d ? f_vld(a_lo) : f_vld(b_lo);
  end

  // ---- pipeline control; bubbles carry zero swaps so unloaded tags never leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      sw_p0  <= '0;
      sw_p1  <= '0;
      occ_p1 <= '0;
    end else begin
      if (s0_adv) begin
        vld_p0 <= in_valid;
        sw_p0  <= in_valid ? {sw_b, sw_a} : 2'b00;
      end
      if (s1_adv) begin
        vld_p1 <= vld_p0;
        sw_p1  <= vld_p0 ? {sw_d, sw_c} : 2'b00;
        occ_p1 <= vld_p0 ? occ_nxt : 4'b0000;
      end
    end
  end

  // ---- golden epoch: free-running, independent of traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt <= '0;
      gold_id   <= '0;
    end else if (epoch_cnt == CNT_LAST) begin
      epoch_cnt <= '0;
      gold_id   <= (gold_id == GOLD_LAST) ? '0 : gold_id + ID_W'(1);
    end else begin
      epoch_cnt <= epoch_cnt + CNT_W'(1);
    end
  end

  assign sw_s0       = sw_p0;
  assign sw_s0_valid = vld_p0;
  assign sw_s1       = sw_p1;
  assign out_valid   = vld_p1;
  assign out_vld     = occ_p1;

endmodule

// File: tb/tb_pn_swap_scheduler.sv
// Directed bench for pn_swap_scheduler: hand-computed swaps, occupancy,
// backpressure scoreboard, golden epoch and asynchronous reset.
module tb_pn_swap_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vld;
  logic [31:0] in_age;
  logic [15:0] in_src;
  logic [1:0]  sw_s0;
  logic        sw_s0_valid;
  logic [1:0]  sw_s1;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_vld;
  logic [3:0]  gold_id;

  int checks = 0;
  int errors = 0;

  pn_swap_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vld(in_vld), .in_age(in_age), .in_src(in_src),
    .sw_s0(sw_s0), .sw_s0_valid(sw_s0_valid), .sw_s1(sw_s1),
    .out_valid(out_valid), .out_ready(out_ready), .out_vld(out_vld),
    .gold_id(gold_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Network model: age landing on dout0 for the given input ages and swaps.
  function automatic logic [7:0] dout0_age(input logic [31:0] ages, input logic [1:0] w0,
                                           input logic [1:0] w1);
    logic [7:0] a_up, b_up;
    a_up = w0[0] ? ages[23:16] : ages[31:24];
    b_up = w0[1] ? ages[7:0]   : ages[15:8];
    return w1[0] ? b_up : a_up;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_vld = '0; in_age = '0; in_src = '0;
    step; step;
    rst_n = 1'b1;
  endtask

  // Push the currently driven group into an empty pipeline and collect its results.
  task automatic run_group(output logic [1:0] o_sw0, output logic o_s0v,
                           output logic [1:0] o_sw1, output logic o_ov, output logic [3:0] o_vld);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step;
    o_sw0 = sw_s0; o_s0v = sw_s0_valid;
    in_valid = 1'b0;
    step;
    o_sw1 = sw_s1; o_ov = out_valid; o_vld = out_vld;
    step;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_vld = 4'hF; in_age = 32'h28_1E_14_0A; in_src = 16'h4321;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    step; step; step;
    checks++; if (sw_s0_valid !== 1'b0) begin errors++; $display("FAIL reset_s0v: got %b expected 0", sw_s0_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outv: got %b expected 0", out_valid); end
    checks++; if (sw_s0 !== 2'b00 || sw_s1 !== 2'b00) begin errors++; $display("FAIL reset_sw: got %b/%b expected 00/00", sw_s0, sw_s1); end
    checks++; if (out_vld !== 4'b0000) begin errors++; $display("FAIL reset_outvld: got %b expected 0000", out_vld); end
    checks++; if (gold_id !== 4'd0) begin errors++; $display("FAIL reset_gold: got %0d expected 0", gold_id); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b expected 1", in_ready); end
    step;
  endtask

  task automatic test_age_order;
    logic [1:0] w0, w1; logic s0v, ov; logic [3:0] v;
    in_vld = 4'hF; in_age = 32'h28_1E_14_0A; in_src = 16'h4321;
    run_group(w0, s0v, w1, ov, v);
    checks++; if (s0v !== 1'b1 || w0 !== 2'b11) begin errors++; $display("FAIL age_sw0: got v=%b sw=%b expected v=1 sw=11", s0v, w0); end
    checks++; if (ov !== 1'b1 || w1 !== 2'b11) begin errors++; $display("FAIL age_sw1: got v=%b sw=%b expected v=1 sw=11", ov, w1); end
    checks++; if (v !== 4'b1111) begin errors++; $display("FAIL age_outvld: got %b expected 1111", v); end
    checks++; if (dout0_age(in_age, w0, w1) !== 8'd10) begin errors++; $display("FAIL age_dout0: got %0d expected 10", dout0_age(in_age, w0, w1)); end
  endtask

  task automatic test_wrap;
    logic [1:0] w0, w1; logic s0v, ov; logic [3:0] v;
    in_vld = 4'b1100; in_age = 32'h05_FA_00_00; in_src = 16'h2143;
    run_group(w0, s0v, w1, ov, v);
    checks++; if (w0 !== 2'b01) begin errors++; $display("FAIL wrap_sw0: got %b expected 01", w0); end
    checks++; if (w1 !== 2'b00 || ov !== 1'b1) begin errors++; $display("FAIL wrap_sw1: got v=%b sw=%b expected v=1 sw=00", ov, w1); end
    checks++; if (v !== 4'b0101) begin errors++; $display("FAIL wrap_outvld: got %b expected 0101", v); end
    checks++; if (dout0_age(in_age, w0, w1) !== 8'd250) begin errors++; $display("FAIL wrap_dout0: got %0d expected 250", dout0_age(in_age, w0, w1)); end
  endtask

  task automatic test_all_invalid;
    logic [1:0] w0, w1; logic s0v, ov; logic [3:0] v;
    in_vld = 4'b0000; in_age = 32'h01_02_03_04; in_src = 16'h1234;
    run_group(w0, s0v, w1, ov, v);
    checks++; if (s0v !== 1'b1 || w0 !== 2'b00) begin errors++; $display("FAIL inval_sw0: got v=%b sw=%b expected v=1 sw=00", s0v, w0); end
    checks++; if (ov !== 1'b1 || w1 !== 2'b00) begin errors++; $display("FAIL inval_sw1: got v=%b sw=%b expected v=1 sw=00", ov, w1); end
    checks++; if (v !== 4'b0000) begin errors++; $display("FAIL inval_outvld: got %b expected 0000", v); end
  endtask

  task automatic test_backpressure;
    logic [3:0]  gv [5];
    logic [31:0] ga [5];
    logic [1:0]  e_sw0 [5];
    logic [1:0]  e_sw1 [5];
    logic [3:0]  e_ov [5];
    int gi = 0, s0i = 0, oi = 0;
    bit saw_block = 0, hold = 0;
    logic [1:0] h_sw1; logic [3:0] h_ov;
    gv = '{4'b1111, 4'b1111, 4'b0001, 4'b0100, 4'b1010};
    ga = '{32'h28_1E_14_0A, 32'h0A_14_1E_28, 32'h00_00_00_07, 32'h00_09_00_00, 32'h3C_00_32_00};
    e_sw0 = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b00};
    e_sw1 = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
    e_ov  = '{4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b0011};
    in_src = 16'h9999;
    for (int c = 0; c < 40 && oi < 5; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (gi < 5) begin in_valid = 1'b1; in_vld = gv[gi]; in_age = ga[gi]; end
      else in_valid = 1'b0;
      #1;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || sw_s1 !== h_sw1 || out_vld !== h_ov) begin
          errors++; $display("FAIL bp_hold c%0d: got v=%b sw=%b vld=%b expected v=1 sw=%b vld=%b", c, out_valid, sw_s1, out_vld, h_sw1, h_ov);
        end
      end
      if (c == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      end
      if (!in_ready) saw_block = 1;
      if (sw_s0_valid && (!out_valid || out_ready)) begin
        checks++;
        if (s0i >= 5) begin errors++; $display("FAIL bp_s0_extra: got group %0d expected at most 5", s0i); end
        else if (sw_s0 !== e_sw0[s0i]) begin errors++; $display("FAIL bp_sw0 g%0d: got %b expected %b", s0i, sw_s0, e_sw0[s0i]); end
        s0i++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sw_s1 !== e_sw1[oi] || out_vld !== e_ov[oi]) begin
          errors++; $display("FAIL bp_out g%0d: got sw=%b vld=%b expected sw=%b vld=%b", oi, sw_s1, out_vld, e_sw1[oi], e_ov[oi]);
        end
        oi++;
      end
      hold = out_valid && !out_ready;
      h_sw1 = sw_s1; h_ov = out_vld;
      if (in_valid && in_ready) gi++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (oi != 5) begin errors++; $display("FAIL bp_count: got %0d groups expected 5 (cycle budget)", oi); end
    checks++; if (s0i != 5) begin errors++; $display("FAIL bp_s0_count: got %0d expected 5", s0i); end
    checks++; if (!saw_block) begin errors++; $display("FAIL bp_block: got in_ready never low expected low during stall"); end
    checks++; if (out_valid !== 1'b0 || sw_s0_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got outv=%b s0v=%b expected 0/0", out_valid, sw_s0_valid); end
  endtask

  task automatic test_golden;
    logic [1:0] w0, w1; logic s0v, ov; logic [3:0] v;
    int k;
    do_reset;
    in_vld = 4'hF; in_age = 32'h64_03_02_01; in_src = 16'h0765;
    run_group(w0, s0v, w1, ov, v);
    checks++; if (w0 !== 2'b10 || w1 !== 2'b10) begin errors++; $display("FAIL gold0_sw: got %b/%b expected 10/10", w0, w1); end
    checks++; if (dout0_age(in_age, w0, w1) !== 8'd100) begin errors++; $display("FAIL gold0_dout0: got %0d expected 100", dout0_age(in_age, w0, w1)); end
    for (k = 0; k < 100 && gold_id !== 4'd1; k++) step;
    checks++; if (gold_id !== 4'd1) begin errors++; $display("FAIL gold_advance: got %0d expected 1 (cycle budget)", gold_id); end
    run_group(w0, s0v, w1, ov, v);
    checks++; if (w0 !== 2'b11 || w1 !== 2'b11) begin errors++; $display("FAIL gold1_sw: got %b/%b expected 11/11", w0, w1); end
    checks++; if (dout0_age(in_age, w0, w1) !== 8'd1) begin errors++; $display("FAIL gold1_dout0: got %0d expected 1", dout0_age(in_age, w0, w1)); end
  endtask

  task automatic test_async_reset;
    in_vld = 4'hF; in_age = 32'h28_1E_14_0A; in_src = 16'h4321;
    out_ready = 1'b0; in_valid = 1'b1;
    step; step;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || sw_s0_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL areset_full: got outv=%b s0v=%b rdy=%b expected 1/1/0", out_valid, sw_s0_valid, in_ready);
    end
    checks++; if (gold_id !== 4'd1) begin errors++; $display("FAIL areset_pre_gold: got %0d expected 1", gold_id); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || sw_s0_valid !== 1'b0) begin
      errors++; $display("FAIL areset_clear: got outv=%b s0v=%b expected 0/0", out_valid, sw_s0_valid);
    end
    checks++; if (gold_id !== 4'd0 || out_vld !== 4'b0000 || sw_s1 !== 2'b00) begin
      errors++; $display("FAIL areset_state: got gold=%0d vld=%b sw1=%b expected 0/0000/00", gold_id, out_vld, sw_s1);
    end
    step;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
    step;
  endtask

  task automatic test_epoch;
    do_reset;
    repeat (63) step;
    checks++; if (gold_id !== 4'd0) begin errors++; $display("FAIL epoch_63: got %0d expected 0", gold_id); end
    step;
    checks++; if (gold_id !== 4'd1) begin errors++; $display("FAIL epoch_64: got %0d expected 1", gold_id); end
    repeat (64 * 14) step;
    checks++; if (gold_id !== 4'd15) begin errors++; $display("FAIL epoch_960: got %0d expected 15", gold_id); end
    repeat (64) step;
    checks++; if (gold_id !== 4'd0) begin errors++; $display("FAIL epoch_wrap: got %0d expected 0", gold_id); end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_vld = '0; in_age = '0; in_src = '0;
    test_reset;
    test_age_order;
    test_wrap;
    test_all_invalid;
    test_backpressure;
    test_golden;
    test_async_reset;
    test_epoch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
